cpu_power_sequencer: RTL



---
 rtl/cpu_power_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cpu_power_sequencer.sv
// Per-CPU power-up / reset sequencer: ramps the supply, holds reset, then
// waits for the heartbeat, retrying the reset a bounded number of times.
module cpu_power_sequencer #(
    parameter int CNT_W     = 24,
    parameter int RAMP_CYC  = 50000,
    parameter int RST_CYC   = 10000,
    parameter int BOOT_CYC  = 5000000,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_req,
    input  logic       reset_req,
    input  logic       alive,
    output logic       power_on,
    output logic       reset_pin_n,
    output logic       ready,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_BOOT  = 3'd3,
        S_RUN   = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             power_on_q, power_on_d;
    logic             reset_n_q, reset_n_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            S_OFF:  if (power_req) state_d = S_RAMP;
            S_RAMP: if (cnt_q == RAMP_LAST) state_d = S_HOLD;
            S_HOLD: if (cnt_q == HOLD_LAST) state_d = S_BOOT;
            S_BOOT: begin
                // A heartbeat wins over everything; an explicit reset request
                // beats a coincident timeout so it does not consume a retry.
                if (alive) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else if (reset_req) begin
                    state_d = S_HOLD;
                end else if (cnt_q == BOOT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        state_d = S_HOLD;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_RUN:  if (reset_req) state_d = S_HOLD;
            S_FAULT: begin
                if (reset_req) begin
                    state_d = S_HOLD;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_OFF;
                retry_d = '0;
            end
        endcase

        if (!power_req && state_q != S_OFF) begin
            state_d = S_OFF;
            retry_d = '0;
        end

        cnt_d = '0;
        if (state_d == state_q && state_q inside {S_RAMP, S_HOLD, S_BOOT})
            cnt_d = cnt_q + CNT_W'(1);

        // Pins are decoded from the next state so they flip on the same edge.
        power_on_d = (state_d != S_OFF);
        reset_n_d  = state_d inside {S_BOOT, S_RUN, S_FAULT};
        ready_d    = (state_d == S_RUN);
        busy_d     = state_d inside {S_RAMP, S_HOLD, S_BOOT};
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            retry_q    <= '0;
            power_on_q <= 1'b0;
            reset_n_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            power_on_q <= power_on_d;
            reset_n_q  <= reset_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    assign power_on    = power_on_q;
    assign reset_pin_n = reset_n_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign retry_cnt   = retry_q;

endmodule
